// File: rtl/regfile_wr_arbiter.sv
// Write-port controller for the core register file: clears x1..x(REG_NUM-1) after reset,
// then arbitrates the single write port between pipeline writeback (A) and a long-latency unit (B).
module regfile_wr_arbiter #(
    parameter int REG_NUM        = 32,
    parameter int XLEN           = 32,
    parameter int MAX_WAIT       = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [4:0]      a_addr,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_addr,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    output logic            rf_we,
    output logic [4:0]      rf_addr,
    output logic [XLEN-1:0] rf_wd,
    output logic            init_done
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam state_t     RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
    localparam logic [4:0] LAST_IDX    = 5'(REG_NUM - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [4:0]        clr_idx_r;
    logic [3:0]        wait_cnt_r;
    logic              grant_a_s;
    logic              grant_b_s;
    logic              we_s;
    logic [4:0]        addr_s;
    logic [XLEN-1:0]   wd_s;

    // Next-state and write-port selection; grant is purely combinational for zero-cycle latency.
    always_comb begin
        state_nxt_s = state_r;
        grant_a_s   = 1'b0;
        grant_b_s   = 1'b0;
        we_s        = 1'b0;
        addr_s      = 5'd0;
        wd_s        = {XLEN{1'b0}};
        case (state_r)
            CLEAR: begin
                we_s   = 1'b1;
                addr_s = clr_idx_r;
                if (clr_idx_r == LAST_IDX) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            RUN: begin
                grant_b_s = b_valid & ((wait_cnt_r == MAX_WAIT_C) | ~a_valid);
                grant_a_s = a_valid & ~grant_b_s;
                if (grant_b_s) begin
                    addr_s = b_addr;
                    wd_s   = b_data;
                end else if (grant_a_s) begin
                    addr_s = a_addr;
                    wd_s   = a_data;
                end else begin
                    addr_s = 5'd0;
                    wd_s   = {XLEN{1'b0}};
                end
                // x0 writes still handshake, but never reach the file.
                we_s = (grant_a_s | grant_b_s) & (addr_s != 5'd0);
            end
            default: begin
                state_nxt_s = RESET_STATE;
            end
        endcase
    end

    // Outputs are forced low directly by reset so they drop without waiting for a clock edge.
    assign a_ready   = rst & grant_a_s;
    assign b_ready   = rst & grant_b_s;
    assign rf_we     = rst & we_s;
    assign rf_addr   = rst ? addr_s : 5'd0;
    assign rf_wd     = rst ? wd_s : {XLEN{1'b0}};
    assign init_done = rst & (state_r == RUN);

    // State, clear index and B starvation counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= RESET_STATE;
            clr_idx_r  <= 5'd1;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == CLEAR) begin
                clr_idx_r <= clr_idx_r + 5'd1;
            end else begin
                clr_idx_r <= clr_idx_r;
            end
            if (!b_valid || grant_b_s) begin
                wait_cnt_r <= 4'd0;
            end else if (wait_cnt_r < MAX_WAIT_C) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port controller for the pipelined core's 32-entry register file. After reset it sequences a clear of x1..x(REG_NUM-1) to zero. It then shares the file's single write port (WE3/A3/WD3) between two writeback requesters using valid/ready handshakes: A is the in-order pipeline writeback, B is a long-latency unit such as a load return or mul/div. A has fixed priority, with a starvation guard for B.

## Interface
Parameters:
- REG_NUM, 32: number of architectural registers; x0 is never written.
- XLEN, 32: data width.
- MAX_WAIT, 4: consecutive cycles B may be refused before it gets priority. Legal range is 1..15.
- CLEAR_ON_RESET, 1: 1 runs the clear sequence after reset; 0 goes straight to RUN.

Ports:
- clk, in, 1: core clock. The arbiter state updates on posedge; the register file samples on negedge of the same cycle.
- rst, in, 1: reset, asynchronous and active-low.
- a_valid, in, 1: A requests a write.
- a_addr, in, 5: A destination register.
- a_data, in, XLEN: A write data.
- a_ready, out, 1: A's write is accepted this cycle. While low with a_valid high, the pipeline stalls.
- b_valid, in, 1: B requests a write.
- b_addr, in, 5: B destination register.
- b_data, in, XLEN: B write data.
- b_ready, out, 1: B's write is accepted this cycle.
- rf_we, out, 1: drives register file WE3.
- rf_addr, out, 5: drives A3.
- rf_wd, out, XLEN: drives WD3.
- init_done, out, 1: high once RUN is reached. Held high until the next reset.

## Operation
- States are CLEAR and RUN.
- Reset (rst low) values:
  - state = CLEAR if CLEAR_ON_RESET is 1, else RUN.
  - clr_idx = 1; wait_cnt = 0.
  - All outputs are 0, including init_done, for as long as rst is low.
- CLEAR state:
  - Outputs: rf_we = 1, rf_addr = clr_idx, rf_wd = 0, a_ready = b_ready = 0, init_done = 0.
  - clr_idx increments each cycle.
  - On the cycle with clr_idx = REG_NUM-1, the next state is RUN.
  - Requests arriving during CLEAR are held off, not dropped.
- RUN state: init_done = 1. Grant is combinational from the current inputs and wait_cnt.
  - grant_b = b_valid & (wait_cnt == MAX_WAIT | ~a_valid).
  - grant_a = a_valid & ~grant_b.
  - a_ready = grant_a; b_ready = grant_b.
  - rf_addr and rf_wd are taken from the granted side; both are 0 when nothing is granted.
  - rf_we = (grant_a | grant_b) & (rf_addr != 0).
- x0 writes: a request to x0 is handshaken normally (ready = 1, consumed) but rf_we stays 0.
- wait_cnt, applied at posedge:
  - Cleared to 0 if b_valid = 0 or grant_b = 1.
  - Otherwise incremented, saturating at MAX_WAIT.
  - Width is 4 bits.
- Handshake rules:
  - A transfer occurs when valid & ready are high at posedge.
  - A requester holding valid must keep its addr and data stable until ready.
  - Only one write occurs per cycle, never two.
- Same-address conflict: if A and B target the same register, the register takes the value of whichever write is granted later, in grant order. The arbiter does not merge or reorder writes.

## Timing
- Zero-cycle write latency. The granted data appears on rf_* combinationally in the accept cycle and is written at that cycle's negedge. A read in the next cycle therefore sees it.
- Clear duration is REG_NUM-1 cycles: first rf_we at the first posedge after rst is released, then x1..x31. init_done rises one cycle after the x31 write cycle.
- Starvation bound: B is accepted at most MAX_WAIT+1 cycles after first asserting b_valid. During B's forced grant, a_ready = 0 for exactly that cycle.
- Reset mid-clear or mid-RUN: outputs go to 0 immediately, without waiting for a clock edge. After release, the clear restarts at x1 and wait_cnt restarts at 0. An in-flight request has not transferred unless a posedge saw valid & ready.

## Test plan
- Reset release, CLEAR_ON_RESET = 1: rf_we is high for 31 cycles with rf_addr = 1..31 and rf_wd = 0. init_done rises in cycle 32. a_valid held high from cycle 0 is first accepted in cycle 32.
- RUN, a_valid only, a_addr = 5, a_data = 0xDEADBEEF: same cycle shows a_ready = 1, rf_we = 1, rf_addr = 5, rf_wd = 0xDEADBEEF. A read of x5 in the next cycle returns 0xDEADBEEF.
- a_valid and b_valid held high continuously, MAX_WAIT = 4: A is granted for cycles 0..3 and B in cycle 4. wait_cnt returns to 0. If B reasserts with new data, A is granted again in cycle 5.
- b_valid with b_addr = 0, a_valid low: b_ready = 1 and rf_we = 0. No register changes.
- rst asserted in the middle of CLEAR (after x10 written), held 2 cycles, then released: rf_we drops immediately. The clear restarts at x1, and init_done is delayed by the full 31 cycles.
- A writes x7 = 1 in cycle N; B writes x7 = 2 in cycle N+1: x7 reads 2 from cycle N+2 onward.
